// File: rtl/scan_chain_ctrl_pkg.sv
// Shared state encoding and mode constants for the scan chain sequencer.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scan_state_e;

  localparam logic MODE_SHIFT   = 1'b0;
  localparam logic MODE_CAPTURE = 1'b1;

endpackage

// File: rtl/scan_chain_ctrl_shreg.sv
// scan_shreg: right-shift register with parallel load, shift enable and MSB serial input.
// Exposes both the current and the next value so callers can register derived outputs in step.
module scan_shreg
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next value: load wins over shift; a shift drops bit 0 and brings sin_i in at the MSB.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = W'({sin_i, q_q} >> 1'b1);
    end else begin
      q_d = q_q;
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= {W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o   = q_q;
  assign nxt_o = q_d;

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: serially loads a word into a mux-flop scan chain, optionally pulses capture, unloads old contents.
// Build option: SCAN_CHAIN_CTRL_PARITY_EN adds exp_par input plus rpar / par_err outputs.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 CK,
  input  logic                 LSR,
  input  logic                 start,
  input  logic                 mode,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 sd,
  output logic                 sp,
  output logic                 si,
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
  input  logic                 exp_par,
  output logic                 rpar,
  output logic                 par_err,
`endif
  input  logic                 so
);

  localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sd_q, sd_d;
  logic                 sp_q, sp_d;
  logic                 si_q, si_d;

  logic                 accept_s;
  logic                 shifting_s;
  logic [CHAIN_LEN-1:0] ld_q_s, ld_nxt_s;
  logic [CHAIN_LEN-1:0] unl_q_s, unl_nxt_s;
  logic                 unused_s;

  assign accept_s   = (state_q == IDLE) && start;
  assign shifting_s = (state_q == SHIFT);

  // Load side: bit 0 of the next value is what the first chain flop sees during the coming shift cycle.
  scan_shreg #(.W(CHAIN_LEN)) u_load_sh (
    .clk_i      (CK),
    .rst_i      (LSR),
    .load_i     (accept_s),
    .load_val_i (load_data),
    .shift_i    (shifting_s),
    .sin_i      (1'b0),
    .q_o        (ld_q_s),
    .nxt_o      (ld_nxt_s)
  );

  scan_shreg #(.W(CHAIN_LEN)) u_unload_sh (
    .clk_i      (CK),
    .rst_i      (LSR),
    .load_i     (accept_s),
    .load_val_i ({CHAIN_LEN{1'b0}}),
    .shift_i    (shifting_s),
    .sin_i      (so),
    .q_o        (unl_q_s),
    .nxt_o      (unl_nxt_s)
  );

  assign unused_s = ^{ld_q_s, ld_nxt_s, unl_q_s};

  // Sequencer next state; SHIFT leaves on the edge where the counter sits at its last value.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = (mode_q == MODE_CAPTURE) ? CAPTURE : DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift counter and latched mode; the counter holds at its last value rather than wrapping.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (accept_s) begin
      cnt_d  = {CNT_W{1'b0}};
      mode_d = mode;
    end else if (shifting_s && (cnt_q != CNT_LAST)) begin
      cnt_d  = cnt_q + CNT_W'(1);
    end else begin
      cnt_d  = cnt_q;
    end
  end

  // Output flops decoded from the next state so every chain control is glitch-free.
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT) || (state_d == CAPTURE);
    done_d  = (state_d == DONE);
    sd_d    = (state_d == SHIFT);
    sp_d    = busy_d;
    si_d    = (state_d == SHIFT) ? ld_nxt_s[0] : 1'b0;
    rdata_d = (state_d == DONE) ? unl_nxt_s : rdata_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CK) begin
    if (LSR) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      mode_q  <= MODE_SHIFT;
      rdata_q <= {CHAIN_LEN{1'b0}};
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sd_q    <= 1'b0;
      sp_q    <= 1'b0;
      si_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sd_q    <= sd_d;
      sp_q    <= sp_d;
      si_q    <= si_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sd    = sd_q;
  assign sp    = sp_q;
  assign si    = si_q;

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
  logic exp_par_q, exp_par_d;
  logic rpar_q, rpar_d;
  logic par_err_q, par_err_d;

  function automatic logic calc_par(input logic [CHAIN_LEN-1:0] w);
    calc_par = ^w;
  endfunction

  // Parity travels with rdata; the error flag is judged against the expectation latched at start.
  always_comb begin
    exp_par_d = exp_par_q;
    rpar_d    = rpar_q;
    par_err_d = par_err_q;
    if (state_d == DONE) begin
      rpar_d    = calc_par(unl_nxt_s);
      par_err_d = (calc_par(unl_nxt_s) != exp_par_q);
    end else if (accept_s) begin
      exp_par_d = exp_par;
      par_err_d = 1'b0;
    end else begin
      par_err_d = par_err_q;
    end
  end

  // Parity registers with synchronous reset.
  always_ff @(posedge CK) begin
    if (LSR) begin
      exp_par_q <= 1'b0;
      rpar_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      exp_par_q <= exp_par_d;
      rpar_q    <= rpar_d;
      par_err_q <= par_err_d;
    end
  end

  assign rpar    = rpar_q;
  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-flop mux-flop chain model (D0 tied to 8'hC3).
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic         CK = 1'b0;
  logic         LSR, start, mode;
  logic [N-1:0] load_data;
  logic         ready, busy, done, sd, sp, si, so;
  logic [N-1:0] rdata;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
  logic         exp_par, rpar, par_err;
`endif

  logic [N-1:0] chain      = 8'hA5;
  logic         preset_req = 1'b0;
  logic [N-1:0] preset_val = 8'hA5;
  int           n_tests = 0;
  int           n_fail  = 0;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CK        (CK),
    .LSR       (LSR),
    .start     (start),
    .mode      (mode),
    .load_data (load_data),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .sd        (sd),
    .sp        (sp),
    .si        (si),
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    .exp_par   (exp_par),
    .rpar      (rpar),
    .par_err   (par_err),
`endif
    .so        (so)
  );

  always #5 CK = ~CK;

  // chain[0] is the last flop (drives so), chain[N-1] the first flop (fed by si).
  assign so = chain[0];
  always @(posedge CK) begin
    if (preset_req) chain <= preset_val;
    else if (sp === 1'b1) chain <= (sd === 1'b1) ? {si, chain[N-1:1]} : 8'hC3;
  end

  typedef struct {
    logic         m;
    logic [N-1:0] ld;
    int           ign;
    logic [N-1:0] exp_rd;
    logic [N-1:0] exp_chain;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preset_chain(input logic [N-1:0] v);
    @(negedge CK);
    preset_val = v;
    preset_req = 1'b1;
    @(negedge CK);
    preset_req = 1'b0;
  endtask

  // One operation; ign>0 re-pulses start in that cycle to check it is ignored.
  task automatic run_op(input logic m, input logic [N-1:0] ld, input int ign,
                        input logic [N-1:0] exp_rd, input logic [N-1:0] exp_chain);
    int done_cyc, done_cnt, sd_cnt, cap_cnt, busy_cnt, sh_idx, si_bad;
    logic [N-1:0] rd_at_done;
    done_cyc = 0; done_cnt = 0; sd_cnt = 0; cap_cnt = 0; busy_cnt = 0; sh_idx = 0; si_bad = 0;
    rd_at_done = '0;
    @(negedge CK);
    start = 1'b1; mode = m; load_data = ld;
    @(posedge CK);
    for (int k = 1; k <= 22; k++) begin
      @(negedge CK);
      start     = (k == ign);
      load_data = (k == ign) ? ~ld : ld;
      if (sd === 1'b1) begin
        sd_cnt++;
        if (sp !== 1'b1 || sh_idx >= N) si_bad++;
        else if (si !== ld[sh_idx]) si_bad++;
        sh_idx++;
      end else if (sp === 1'b1) begin
        cap_cnt++;
        if (si !== 1'b0) si_bad++;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc   = k;
          rd_at_done = rdata;
        end
      end
    end
    start = 1'b0;
    chk("done_latency", 32'(done_cyc), m ? 32'd10 : 32'd9);
    chk("done_count",   32'(done_cnt), 32'd1);
    chk("sd_cycles",    32'(sd_cnt), 32'd8);
    chk("capture_cycles", 32'(cap_cnt), m ? 32'd1 : 32'd0);
    chk("busy_cycles",  32'(busy_cnt), m ? 32'd9 : 32'd8);
    chk("si_sequence",  32'(si_bad), 32'd0);
    chk("rdata_at_done", 32'(rd_at_done), 32'(exp_rd));
    chk("rdata_held",   32'(rdata), 32'(exp_rd));
    chk("chain_after",  32'(chain), 32'(exp_chain));
    chk("ready_after",  32'(ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, dcnt;
    logic [N-1:0] r1, r2;
    logic rdy10, bsy10, bsy11;

    LSR = 1'b1; start = 1'b0; mode = 1'b0; load_data = '0;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    exp_par = 1'b0;
`endif
    vecs[0] = '{1'b0, 8'h3C, 0, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 8'h0F, 0, 8'h3C, 8'hC3};
    vecs[2] = '{1'b0, 8'h5A, 0, 8'hC3, 8'h5A};
    vecs[3] = '{1'b1, 8'hFF, 3, 8'h5A, 8'hC3};
    vecs[4] = '{1'b0, 8'h00, 0, 8'hC3, 8'h00};
    vecs[5] = '{1'b0, 8'h81, 0, 8'h00, 8'h81};
    vecs[6] = '{1'b0, 8'h42, 3, 8'h81, 8'h42};

    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sd",    32'(sd),    32'd0);
    chk("rst_sp",    32'(sp),    32'd0);
    chk("rst_si",    32'(si),    32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    LSR = 1'b0;

    preset_chain(8'hA5);
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].m, vecs[i].ld, vecs[i].ign, vecs[i].exp_rd, vecs[i].exp_chain);
    end

    // Back-to-back: start held high, chain currently 8'h42.
    d1 = 0; d2 = 0; dcnt = 0; r1 = '0; r2 = '0; rdy10 = 1'b0; bsy10 = 1'b1; bsy11 = 1'b0;
    @(negedge CK);
    start = 1'b1; mode = 1'b0; load_data = 8'h99;
    @(posedge CK);
    for (int k = 1; k <= 22; k++) begin
      @(negedge CK);
      if (k == 11) start = 1'b0;
      if (k == 10) begin rdy10 = ready; bsy10 = busy; end
      if (k == 11) bsy11 = busy;
      if (done === 1'b1) begin
        dcnt++;
        if (d1 == 0) begin d1 = k; r1 = rdata; end
        else begin d2 = k; r2 = rdata; end
      end
    end
    chk("b2b_done_count", 32'(dcnt), 32'd2);
    chk("b2b_first_done", 32'(d1), 32'd9);
    chk("b2b_second_done", 32'(d2), 32'd19);
    chk("b2b_first_rdata", 32'(r1), 32'h42);
    chk("b2b_second_rdata", 32'(r2), 32'h99);
    chk("b2b_idle_ready", 32'(rdy10), 32'd1);
    chk("b2b_idle_busy", 32'(bsy10), 32'd0);
    chk("b2b_restart_busy", 32'(bsy11), 32'd1);

    // Reset asserted for two cycles in the middle of SHIFT.
    @(negedge CK);
    start = 1'b1; mode = 1'b0; load_data = 8'h77;
    @(posedge CK);
    @(negedge CK);
    start = 1'b0;
    @(negedge CK);
    @(negedge CK);
    chk("midshift_sd", 32'(sd), 32'd1);
    LSR = 1'b1;
    @(posedge CK);
    @(negedge CK);
    chk("midrst_sd",    32'(sd),    32'd0);
    chk("midrst_sp",    32'(sp),    32'd0);
    chk("midrst_si",    32'(si),    32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done",  32'(done),  32'd0);
    @(posedge CK);
    @(negedge CK);
    LSR = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge CK);
      if (done === 1'b1) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    chk("midrst_idle_ready", 32'(ready), 32'd1);

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    preset_chain(8'hA5);
    exp_par = 1'b0;
    run_op(1'b0, 8'h01, 0, 8'hA5, 8'h01);
    chk("par_rpar_even", 32'(rpar), 32'd0);
    chk("par_err_clean", 32'(par_err), 32'd0);
    exp_par = 1'b0;
    run_op(1'b0, 8'h00, 0, 8'h01, 8'h00);
    chk("par_rpar_odd", 32'(rpar), 32'd1);
    chk("par_err_set", 32'(par_err), 32'd1);
    @(negedge CK);
    start = 1'b1; mode = 1'b0; load_data = 8'h00;
    @(posedge CK);
    @(negedge CK);
    start = 1'b0;
    chk("par_err_cleared", 32'(par_err), 32'd0);
    repeat (12) @(negedge CK);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
